// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: result-bus field widths, the broadcast record type and a tag accessor.
package cdb_arbiter_pkg;
    localparam int RSV_ID_W = 4;
    localparam int DATA_W   = 16;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    typedef struct packed {
        logic [RSV_ID_W-1:0] rsv_id;
        logic [DATA_W-1:0]   data;
    } cdb_t;

    function automatic logic [RSV_ID_W-1:0] cdb_tag(input cdb_t c);
        return c.rsv_id;
    endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: functional-unit write-back ports plus the broadcast side of the common data bus.
interface cdb_arbiter_if import cdb_arbiter_pkg::*; #(parameter int N_SOURCES = 4);
    logic [N_SOURCES-1:0] i_valid;
    logic [N_SOURCES-1:0] i_ready;
    cdb_t [N_SOURCES-1:0] i_data;
    logic                 i_flush;
    logic                 cdb_valid;
    cdb_t                 cdb;
    logic                 o_idle;

    modport master(output i_valid, i_data, i_flush, input i_ready, cdb_valid, cdb, o_idle);
    modport slave(input i_valid, i_data, i_flush, output i_ready, cdb_valid, cdb, o_idle);
endinterface

// File: rtl/cdb_arbiter_src_fifo.sv
// cdb_src_fifo: per-source result buffer; a flush clears pointers and drops any same-cycle push.
module cdb_src_fifo import cdb_arbiter_pkg::*; #(parameter int DEPTH_W = 2) (
    input  logic clk,
    input  logic nrst,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  cdb_t din,
    output logic full,
    output logic empty,
    output cdb_t head
);
    localparam int DEPTH = 1 << DEPTH_W;
    cdb_t mem [DEPTH];
    logic [DEPTH_W-1:0] rd, wr;
    logic [DEPTH_W:0] count;
    logic do_push, do_pop;
    assign full    = count == (DEPTH_W+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd];
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            count <= count + (DEPTH_W+1)'(do_push) - (DEPTH_W+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr] <= din;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers FU results per source and broadcasts one per cycle on the CDB, round-robin.
module cdb_arbiter import cdb_arbiter_pkg::*; #(
    parameter int N_SOURCES    = 4,
    parameter int FIFO_DEPTH_W = 2
) (
    input logic clk,
    input logic nrst,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = N_SOURCES > 1 ? $clog2(N_SOURCES) : 1;
    logic [N_SOURCES-1:0] full, empty;
    cdb_t head [N_SOURCES];
    logic [PTR_W-1:0] rr_ptr, gnt, idx;
    logic gnt_any, cdb_valid;
    cdb_t cdb;

    for (genvar g = 0; g < N_SOURCES; g++) begin : g_src
        cdb_src_fifo #(.DEPTH_W(FIFO_DEPTH_W)) u_fifo (
            .clk   (clk),
            .nrst  (nrst),
            .push  (bus.i_valid[g]),
            .pop   (gnt_any && gnt == PTR_W'(g)),
            .flush (bus.i_flush),
            .din   (bus.i_data[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .head  (head[g])
        );
    end

    // Scan from lowest priority up so the last hit is the first non-empty source after rr_ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt     = rr_ptr;
        idx     = rr_ptr;
        for (int i = N_SOURCES - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(rr_ptr) + i) % N_SOURCES);
            if (!empty[idx]) begin
                gnt_any = 1'b1;
                gnt     = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cdb_valid <= 1'b0;
            cdb       <= '0;
            rr_ptr    <= '0;
        end else if (bus.i_flush) begin
            cdb_valid <= 1'b0;
        end else if (gnt_any) begin
            cdb_valid <= 1'b1;
            cdb       <= head[gnt];
            rr_ptr    <= gnt == PTR_W'(N_SOURCES - 1) ? '0 : gnt + 1'b1;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

    assign bus.i_ready   = ~full;
    assign bus.cdb_valid = cdb_valid;
    assign bus.cdb       = cdb;
    assign bus.o_idle    = &empty && !cdb_valid;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: random and directed traffic checked against a queue-based model of the CDB arbiter.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;
    localparam int N = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    cdb_arbiter_if #(.N_SOURCES(N)) bus ();
    cdb_arbiter #(.N_SOURCES(N), .FIFO_DEPTH_W(2)) dut (.clk(clk), .nrst(nrst), .bus(bus));
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    cdb_t q [N][$];
    cdb_t din [N];
    int rr = 0;
    logic e_valid = 1'b0;
    cdb_t e_cdb = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = q[k].size() != DEPTH;
        return r;
    endfunction

    function automatic logic exp_idle();
        logic e = !e_valid;
        for (int k = 0; k < N; k++) if (q[k].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(bus.cdb_valid), 32'(e_valid));
        check({tag, ".cdb"}, 32'(bus.cdb), 32'(e_cdb));
        check({tag, ".ready"}, 32'(bus.i_ready), 32'(exp_ready()));
        check({tag, ".idle"}, 32'(bus.o_idle), 32'(exp_idle()));
    endtask

    // One clock: drive inputs, advance the model by one edge, then compare.
    task automatic step(input logic [N-1:0] v, input logic fl, input string tag);
        logic [N-1:0] rdy;
        int g;
        @(negedge clk);
        bus.i_valid = v;
        bus.i_flush = fl;
        for (int k = 0; k < N; k++) bus.i_data[k] = din[k];
        rdy = exp_ready();
        if (fl) begin
            for (int k = 0; k < N; k++) q[k].delete();
            e_valid = 1'b0;
        end else begin
            g = -1;
            for (int i = 0; i < N; i++)
                if (g < 0 && q[(rr + i) % N].size() > 0) g = (rr + i) % N;
            e_valid = g >= 0;
            if (g >= 0) begin
                e_cdb = q[g].pop_front();
                rr = (g + 1) % N;
            end
            for (int k = 0; k < N; k++) if (v[k] && rdy[k]) q[k].push_back(din[k]);
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic rand_din();
        for (int k = 0; k < N; k++) din[k] = cdb_t'($urandom);
    endtask

    initial begin
        bus.i_valid = '0;
        bus.i_flush = 1'b0;
        bus.i_data = '0;
        for (int k = 0; k < N; k++) din[k] = '0;
        #2;
        check_outputs("reset");
        @(negedge clk);
        nrst = 1'b1;

        din[1] = '{rsv_id: 4'd5, data: 16'hDEAD};
        step(4'b0010, 1'b0, "single.push");
        check("single.latency", 32'(bus.cdb_valid), 32'd0);
        step(4'b0000, 1'b0, "single.wait");
        check("single.tag", 32'(cdb_tag(bus.cdb)), 32'd5);
        check("single.data", 32'(bus.cdb.data), 32'hDEAD);
        step(4'b0000, 1'b0, "single.done");
        check("single.idle", 32'(bus.o_idle), 32'd1);

        for (int k = 0; k < N; k++) din[k] = '{rsv_id: 4'(k), data: 16'(16'h100 * k)};
        step(4'b1111, 1'b0, "all.push");
        for (int c = 0; c < 5; c++) step(4'b0000, 1'b0, "all.drain");

        for (int c = 0; c < 12; c++) begin
            for (int k = 0; k < N; k++) din[k] = '{rsv_id: 4'(k), data: 16'(c)};
            step(4'b1111, 1'b0, "full.sat");
        end
        for (int c = 0; c < 20; c++) step(4'b0000, 1'b0, "full.drain");

        for (int c = 0; c < 20; c++) begin
            din[0] = '{rsv_id: 4'd0, data: 16'(c)};
            din[2] = '{rsv_id: 4'd2, data: 16'hBEEF};
            step(c == 3 ? 4'b0101 : 4'b0001, 1'b0, "fair");
        end
        for (int c = 0; c < 8; c++) step(4'b0000, 1'b0, "fair.drain");

        rand_din();
        step(4'b1111, 1'b0, "flush.fill");
        rand_din();
        step(4'b0011, 1'b0, "flush.fill");
        rand_din();
        step(4'b1111, 1'b1, "flush.hit");
        for (int c = 0; c < 4; c++) step(4'b0000, 1'b0, "flush.after");

        for (int c = 0; c < 2000; c++) begin
            rand_din();
            step(4'($urandom), $urandom_range(31) == 0, "rand");
        end
        for (int c = 0; c < 20; c++) step(4'b0000, 1'b0, "rand.drain");

        rand_din();
        step(4'b1111, 1'b0, "arst.fill");
        rand_din();
        step(4'b1111, 1'b0, "arst.fill");
        check("arst.pre", 32'(bus.cdb_valid), 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        for (int k = 0; k < N; k++) q[k].delete();
        rr = 0;
        e_valid = 1'b0;
        e_cdb = '0;
        check_outputs("arst");
        bus.i_valid = '0;
        @(negedge clk);
        nrst = 1'b1;
        for (int c = 0; c < 6; c++) step(4'b0000, 1'b0, "arst.after");

        for (int c = 0; c < 500; c++) begin
            rand_din();
            step(4'($urandom), $urandom_range(63) == 0, "rand2");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
